// File: rtl/irq_priority_ctrl_if.sv
// Bus between the interrupt controller and the CPU core: raw IRQ lines, masks,
// the ack/return handshake and the request/status outputs.
interface irq_priority_ctrl_if #(
  parameter int N_IRQ = 3,
  parameter int ID_W  = 2,
  parameter int WIDTH = 32
);
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_mask;
  logic             glb_en;
  logic             int_ack;
  logic             int_ret;
  logic             int_req;
  logic [ID_W-1:0]  int_id;
  logic [WIDTH-1:0] int_vec;
  logic [N_IRQ-1:0] irw;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] ovf;

  modport master (
    output irq_in, irq_mask, glb_en, int_ack, int_ret,
    input  int_req, int_id, int_vec, irw, pend, ovf
  );

  modport slave (
    input  irq_in, irq_mask, glb_en, int_ack, int_ret,
    output int_req, int_id, int_vec, irw, pend, ovf
  );
endinterface

// File: rtl/irq_priority_ctrl.sv
// N-channel fixed-priority interrupt controller with edge capture, masking,
// nested in-service tracking (irw), preemption and sticky overflow flags.
module irq_priority_ctrl #(
  parameter int                     N_IRQ      = 3,
  parameter int                     ID_W       = 2,
  parameter int                     WIDTH      = 32,
  parameter logic [WIDTH-1:0]       VEC_BASE   = 'h100,
  parameter int unsigned            VEC_STRIDE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  irq_priority_ctrl_if.slave   bus
);

  logic [N_IRQ-1:0] prev_q, prev_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] irw_q,  irw_d;
  logic [N_IRQ-1:0] ovf_q,  ovf_d;
  logic             req_q,  req_d;
  logic [ID_W-1:0]  id_q,   id_d;
  logic [WIDTH-1:0] vec_q,  vec_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] ack_sel;
  logic [N_IRQ-1:0] ret_sel;
  logic [N_IRQ-1:0] pend_kept;
  logic [N_IRQ-1:0] elig;
  logic             ack_ok;

  always_comb begin
    prev_d  = bus.irq_in;
    rise    = bus.irq_in & ~prev_q;
    ack_ok  = bus.int_ack & req_q;
    ack_sel = '0;
    ret_sel = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (ack_ok && id_q == ID_W'(i)) ack_sel[i] = 1'b1;
      if (irw_q[i]) begin
        ret_sel    = '0;
        ret_sel[i] = 1'b1;
      end
    end
    if (!bus.int_ret) ret_sel = '0;

    // Return is applied before the ack's set so both can coexist in one cycle.
    pend_kept = pend_q & ~ack_sel;
    pend_d    = pend_kept | rise;
    ovf_d     = ovf_q | (rise & pend_q & ~ack_sel);
    irw_d     = (irw_q & ~ret_sel) | ack_sel;

    // New edges become requestable one cycle after they are pended.
    elig = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      elig[i] = pend_kept[i] & bus.irq_mask[i] & ((irw_d >> i) == '0);
    end

    req_d = bus.glb_en & (|elig);
    id_d  = id_q;
    vec_d = vec_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (elig[i]) id_d = ID_W'(i);
    end
    if (|elig) vec_d = VEC_BASE + WIDTH'(id_d) * WIDTH'(VEC_STRIDE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= bus.irq_in;
      pend_q <= '0;
      irw_q  <= '0;
      ovf_q  <= '0;
      req_q  <= 1'b0;
      id_q   <= '0;
      vec_q  <= VEC_BASE;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      irw_q  <= irw_d;
      ovf_q  <= ovf_d;
      req_q  <= req_d;
      id_q   <= id_d;
      vec_q  <= vec_d;
    end
  end

  assign bus.int_req = req_q;
  assign bus.int_id  = id_q;
  assign bus.int_vec = vec_q;
  assign bus.irw     = irw_q;
  assign bus.pend    = pend_q;
  assign bus.ovf     = ovf_q;

endmodule
